// File: rtl/mod_ctrl_pkg.sv
// Shared constants, state encoding and the target clamp helper for the
// modulation run-control sequencer.
package mod_ctrl_pkg;

  localparam int MOD_W        = 8;
  localparam int MOD_LIM_DEF  = 120;
  localparam int STEP_DIV_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STOP  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  // Symmetric saturation; -128 lands on -lim because lim is at most 127.
  function automatic logic signed [MOD_W-1:0] clamp_mod(
    input logic signed [MOD_W-1:0] v,
    input logic signed [MOD_W-1:0] lim
  );
    logic signed [MOD_W-1:0] r;
    r = v;
    if (v > lim) r = lim;
    else if (v < -lim) r = -lim;
    return r;
  endfunction

endpackage

// File: rtl/slew_prescaler.sv
// Modulo-STEP_DIV counter; tick is high for the one cycle at terminal count.
module slew_prescaler #(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == TC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= (cnt == TC) ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/mod_sequencer.sv
// Run-control sequencer: slews the signed modulation command toward a clamped
// target, gates the power stage, and latches faults into a zero-command stop.
module mod_sequencer
  import mod_ctrl_pkg::*;
#(
  parameter int STEP_DIV = STEP_DIV_DEF,
  parameter int MOD_LIM  = MOD_LIM_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    fault,
  input  logic                    fault_clr,
  input  logic signed [MOD_W-1:0] target,
  input  logic                    target_vld,
  output logic signed [MOD_W-1:0] mod,
  output logic                    gate_en,
  output logic [1:0]              state,
  output logic                    at_target,
  output logic                    fault_latched
);

  localparam logic signed [MOD_W-1:0] LIM = MOD_W'(MOD_LIM);

  state_t                  state_q, state_nxt;
  logic signed [MOD_W-1:0] mod_q, mod_nxt, tgt_q, tgt_nxt, goal, mod_step;
  logic                    tick, pre_en, pre_clr;

  assign pre_en = (state_q == ST_RUN) || (state_q == ST_STOP);

  slew_prescaler #(.STEP_DIV(STEP_DIV)) u_pre (
    .clk (clk),
    .rst (rst),
    .en  (pre_en),
    .clr (pre_clr),
    .tick(tick)
  );

  assign tgt_nxt  = target_vld ? clamp_mod(target, LIM) : tgt_q;
  // Goal follows the current state, so a same-cycle target load steers the next step.
  assign goal     = (state_q == ST_RUN) ? tgt_q : '0;
  assign mod_step = (mod_q == goal) ? mod_q
                  : (mod_q < goal)  ? mod_q + 8'sd1
                  :                   mod_q - 8'sd1;

  always_comb begin
    state_nxt = state_q;
    mod_nxt   = mod_q;
    pre_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mod_nxt = '0;
        if (start) begin
          state_nxt = ST_RUN;
          pre_clr   = 1'b1;
        end
      end
      ST_RUN: begin
        if (tick) mod_nxt = mod_step;
        if (stop) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (tick) mod_nxt = mod_step;
        if (start && !stop)   state_nxt = ST_RUN;
        else if (mod_q == '0) state_nxt = ST_IDLE;
      end
      ST_FAULT: begin
        mod_nxt = '0;
        if (fault_clr) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Fault overrides everything, including a pending fault_clr.
    if (fault) begin
      state_nxt = ST_FAULT;
      mod_nxt   = '0;
      pre_clr   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mod_q         <= '0;
      tgt_q         <= '0;
      gate_en       <= 1'b0;
      at_target     <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      mod_q         <= mod_nxt;
      tgt_q         <= tgt_nxt;
      gate_en       <= (state_nxt == ST_RUN) || (state_nxt == ST_STOP);
      at_target     <= (state_nxt == ST_RUN) && (mod_nxt == tgt_nxt);
      fault_latched <= (state_nxt == ST_FAULT);
    end
  end

  assign mod   = mod_q;
  assign state = state_q;

endmodule

// File: tb/tb_mod_sequencer.sv
// Directed bench for mod_sequencer with STEP_DIV=4, MOD_LIM=120.
module tb_mod_sequencer;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0, stop = 1'b0, fault = 1'b0, fault_clr = 1'b0;
  logic signed [7:0] target = '0;
  logic              target_vld = 1'b0;
  logic signed [7:0] mod;
  logic              gate_en, at_target, fault_latched;
  logic [1:0]        state;

  int total = 0;
  int bad   = 0;

  mod_sequencer #(.STEP_DIV(4), .MOD_LIM(120)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .fault        (fault),
    .fault_clr    (fault_clr),
    .target       (target),
    .target_vld   (target_vld),
    .mod          (mod),
    .gate_en      (gate_en),
    .state        (state),
    .at_target    (at_target),
    .fault_latched(fault_latched)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1ns past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_target(input logic signed [7:0] t);
    target = t; target_vld = 1'b1;
    cyc(1);
    target_vld = 1'b0;
  endtask

  task automatic test_reset;
    total++; if ({mod, gate_en, state, at_target, fault_latched} !== 13'd0) begin
      bad++; $display("FAIL reset_state: got mod=%0d gate=%b st=%0d at=%b fl=%b, need all 0",
                      mod, gate_en, state, at_target, fault_latched);
    end
    cyc(1); rst = 1'b0;
    load_target(8'sd20);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(10);
    total++; if (mod !== 8'sd2) begin bad++; $display("FAIL reset_preramp: mod=%0d need 2", mod); end
    #2 rst = 1'b1; #1;
    total++; if (mod !== 8'sd0 || gate_en !== 1'b0 || state !== 2'd0) begin
      bad++; $display("FAIL reset_async: mod=%0d gate=%b st=%0d need 0/0/0", mod, gate_en, state);
    end
    cyc(1); rst = 1'b0;
    cyc(8);
    total++; if (mod !== 8'sd0 || gate_en !== 1'b0 || state !== 2'd0) begin
      bad++; $display("FAIL reset_stays_idle: mod=%0d gate=%b st=%0d need 0/0/0", mod, gate_en, state);
    end
  endtask

  task automatic test_ramp_up;
    load_target(8'sd60);
    start = 1'b1; cyc(1); start = 1'b0;
    total++; if (state !== 2'd1 || gate_en !== 1'b1 || mod !== 8'sd0) begin
      bad++; $display("FAIL ramp_enter: st=%0d gate=%b mod=%0d need 1/1/0", state, gate_en, mod);
    end
    cyc(3);
    total++; if (mod !== 8'sd0) begin bad++; $display("FAIL ramp_k3: mod=%0d need 0", mod); end
    cyc(1);
    total++; if (mod !== 8'sd1) begin bad++; $display("FAIL ramp_first_step: mod=%0d need 1", mod); end
    cyc(235);
    total++; if (mod !== 8'sd59 || at_target !== 1'b0) begin
      bad++; $display("FAIL ramp_k239: mod=%0d at=%b need 59/0", mod, at_target);
    end
    cyc(1);
    total++; if (mod !== 8'sd60 || at_target !== 1'b1) begin
      bad++; $display("FAIL ramp_k240: mod=%0d at=%b need 60/1", mod, at_target);
    end
  endtask

  task automatic test_reversal;
    logic signed [7:0] prev;
    bit mono_ok = 1'b1;
    bit seen_zero = 1'b0;
    load_target(-8'sd60);
    for (int i = 0; i < 479; i++) begin
      prev = mod;
      cyc(1);
      if (mod > prev || mod < prev - 8'sd1 || mod < -8'sd60) mono_ok = 1'b0;
      if (mod == 8'sd0) seen_zero = 1'b1;
    end
    total++; if (!mono_ok) begin bad++; $display("FAIL rev_monotonic: got non-monotonic/overshoot, need monotonic"); end
    total++; if (!seen_zero) begin bad++; $display("FAIL rev_through_zero: got no zero, need zero crossing"); end
    total++; if (mod !== -8'sd60 || at_target !== 1'b1) begin
      bad++; $display("FAIL rev_end: mod=%0d at=%b need -60/1", mod, at_target);
    end
  endtask

  task automatic test_stop;
    stop = 1'b1; cyc(1); stop = 1'b0;
    total++; if (state !== 2'd2 || gate_en !== 1'b1 || at_target !== 1'b0) begin
      bad++; $display("FAIL stop_enter: st=%0d gate=%b at=%b need 2/1/0", state, gate_en, at_target);
    end
    cyc(239);
    total++; if (mod !== 8'sd0 || state !== 2'd2 || gate_en !== 1'b1) begin
      bad++; $display("FAIL stop_zero: mod=%0d st=%0d gate=%b need 0/2/1", mod, state, gate_en);
    end
    cyc(1);
    total++; if (state !== 2'd0 || gate_en !== 1'b0) begin
      bad++; $display("FAIL stop_idle: st=%0d gate=%b need 0/0", state, gate_en);
    end
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(240);
    total++; if (mod !== -8'sd60) begin bad++; $display("FAIL stop_reramp: mod=%0d need -60", mod); end
    stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(119);
    total++; if (mod !== -8'sd30 || state !== 2'd2) begin
      bad++; $display("FAIL stop_mid: mod=%0d st=%0d need -30/2", mod, state);
    end
    start = 1'b1; cyc(1); start = 1'b0;
    total++; if (state !== 2'd1 || gate_en !== 1'b1 || mod !== -8'sd30) begin
      bad++; $display("FAIL stop_resume: st=%0d gate=%b mod=%0d need 1/1/-30", state, gate_en, mod);
    end
    cyc(2);
    total++; if (mod !== -8'sd30) begin bad++; $display("FAIL resume_k363: mod=%0d need -30", mod); end
    cyc(1);
    total++; if (mod !== -8'sd31) begin bad++; $display("FAIL resume_no_preclr: mod=%0d need -31", mod); end
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
    total++; if (state !== 2'd2) begin bad++; $display("FAIL stop_over_start: st=%0d need 2", state); end
  endtask

  task automatic test_fault;
    rst = 1'b1; #1; cyc(1); rst = 1'b0;
    load_target(8'sd60);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(100);
    total++; if (mod !== 8'sd25 || state !== 2'd1) begin
      bad++; $display("FAIL fault_pre: mod=%0d st=%0d need 25/1", mod, state);
    end
    fault = 1'b1; cyc(1);
    total++; if (mod !== 8'sd0 || gate_en !== 1'b0 || state !== 2'd3 || fault_latched !== 1'b1) begin
      bad++; $display("FAIL fault_hit: mod=%0d gate=%b st=%0d fl=%b need 0/0/3/1", mod, gate_en, state, fault_latched);
    end
    fault_clr = 1'b1; cyc(2);
    total++; if (state !== 2'd3) begin bad++; $display("FAIL fault_clr_blocked: st=%0d need 3", state); end
    fault = 1'b0; fault_clr = 1'b0; cyc(1);
    total++; if (state !== 2'd3 || fault_latched !== 1'b1) begin
      bad++; $display("FAIL fault_latch: st=%0d fl=%b need 3/1", state, fault_latched);
    end
    fault_clr = 1'b1; cyc(1); fault_clr = 1'b0;
    total++; if (state !== 2'd0 || fault_latched !== 1'b0 || gate_en !== 1'b0) begin
      bad++; $display("FAIL fault_release: st=%0d fl=%b gate=%b need 0/0/0", state, fault_latched, gate_en);
    end
  endtask

  task automatic test_clamp_priority;
    load_target(8'sd127);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(479);
    total++; if (mod !== 8'sd119 || at_target !== 1'b0) begin
      bad++; $display("FAIL clamp_hi_k479: mod=%0d at=%b need 119/0", mod, at_target);
    end
    cyc(1);
    total++; if (mod !== 8'sd120 || at_target !== 1'b1) begin
      bad++; $display("FAIL clamp_hi: mod=%0d at=%b need 120/1", mod, at_target);
    end
    cyc(8);
    total++; if (mod !== 8'sd120) begin bad++; $display("FAIL clamp_hi_hold: mod=%0d need 120", mod); end
    load_target(-8'sd128);
    cyc(959);
    total++; if (mod !== -8'sd120 || at_target !== 1'b1) begin
      bad++; $display("FAIL clamp_lo: mod=%0d at=%b need -120/1", mod, at_target);
    end
    cyc(8);
    total++; if (mod !== -8'sd120) begin bad++; $display("FAIL clamp_lo_hold: mod=%0d need -120", mod); end
    start = 1'b1; stop = 1'b1; fault = 1'b1; cyc(1);
    start = 1'b0; stop = 1'b0; fault = 1'b0;
    total++; if (state !== 2'd3 || mod !== 8'sd0 || gate_en !== 1'b0) begin
      bad++; $display("FAIL prio_run: st=%0d mod=%0d gate=%b need 3/0/0", state, mod, gate_en);
    end
    fault_clr = 1'b1; cyc(1); fault_clr = 1'b0;
    start = 1'b1; stop = 1'b1; fault = 1'b1; cyc(1);
    start = 1'b0; stop = 1'b0; fault = 1'b0;
    total++; if (state !== 2'd3 || gate_en !== 1'b0) begin
      bad++; $display("FAIL prio_idle: st=%0d gate=%b need 3/0", state, gate_en);
    end
  endtask

  initial begin
    #1;
    test_reset;
    test_ramp_up;
    test_reversal;
    test_stop;
    test_fault;
    test_clamp_priority;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_sequencer.md
# mod_sequencer

Run-control sequencer that drives the signed modulation command `mod` of the three-phase modulator (`ModuladorHW`). It accepts start/stop requests and a signed target, slews `mod` toward the target at a programmable rate, and gates the power stage via `gate_en`. It latches external faults and forces an immediate zero-command shutdown. It sits between the control/host logic and the modulator's `mod` input.

## Interface
- `STEP_DIV`, 4: clocks per 1-LSB slew step (≥1).
- `MOD_LIM`, 120: symmetric magnitude clamp on the target (1..127).

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  run request, level-sampled each cycle.
- `stop`  in  1  ramp-down request, level-sampled.
- `fault`  in  1  external fault, level.
- `fault_clr`  in  1  fault acknowledge.
- `target`  in  8 signed  requested modulation index.
- `target_vld`  in  1  load `target` this cycle.
- `mod`  out  8 signed  command to modulator `mod` input.
- `gate_en`  out  1  power-stage enable.
- `state`  out  2  IDLE=0, RUN=1, STOP=2, FAULT=3.
- `at_target`  out  1  high when `state==RUN` and `mod==tgt_q`.
- `fault_latched`  out  1  high while in FAULT.

## Operation
- Reset values: `mod`=0, `gate_en`=0, `state`=IDLE, `at_target`=0, `fault_latched`=0, internal `tgt_q`=0, prescaler=0.
- Target register: on `target_vld`, `tgt_q` <= clamp(`target`, -MOD_LIM, +MOD_LIM). Accepted in every state. -128 clamps to -MOD_LIM.
- Slew: prescaler counts 0..STEP_DIV-1 while in RUN or STOP and wraps. On terminal count, `mod` moves 1 LSB toward the goal unless it already equals the goal. The goal is `tgt_q` in RUN and 0 in STOP. There is no overshoot. Sign crossings pass through 0.
- IDLE: `mod` is held 0. `start`=1 and `fault`=0 moves to RUN, sets `gate_en`=1, and clears the prescaler.
- RUN: tracks `tgt_q`. A new target mid-ramp reverses direction on the next step. `stop` moves to STOP. `start` is ignored.
- STOP: slews to 0. On a cycle with `mod`==0, the next edge enters IDLE and sets `gate_en`=0. `start`=1 in STOP returns to RUN from the current `mod`, without a prescaler clear.
- FAULT: entered from any state on `fault`=1. On that edge, `mod`<=0 and `gate_en`<=0 with no slewing. The block leaves FAULT only on `fault_clr`=1 with `fault`=0, going to IDLE. `fault_clr` with `fault` still high is ignored.
- Priority on simultaneous inputs: `fault` > `stop` > `start`. `target_vld` is independent of state priority. In the same cycle as a step, the new `tgt_q` becomes the goal from the next cycle.

## Timing
- All outputs are registered. Control response is 1 clock after the sampling edge.
- `start` to `gate_en` high: 1 clock. The first `mod` step occurs STEP_DIV clocks after entering RUN.
- Ramp time from 0 to N is N*STEP_DIV clocks. `at_target` asserts in the same cycle `mod` reaches `tgt_q`.
- `fault` to `mod`=0 and `gate_en`=0: 1 clock, regardless of the current `mod`.
- `rst` asserted mid-ramp clears all outputs asynchronously. After release, the block sits in IDLE and needs a fresh `start`.

## Structure
- Package `mod_ctrl_pkg` holds:
  - the state encoding constants (IDLE/RUN/STOP/FAULT),
  - `MOD_W`=8,
  - the default `MOD_LIM` and `STEP_DIV`.
- Sub-module `slew_prescaler` is a parameterised modulo-STEP_DIV counter with `en`, `clr` and a one-cycle `tick` output.
- The top level contains the FSM, the target clamp and the `mod` up/down register.

## Test plan
With STEP_DIV=4 and MOD_LIM=120:
- **Reset:** assert `rst` mid-ramp → `mod`=0, `gate_en`=0, `state`=0 immediately. Stays IDLE after release.
- **Ramp up:** `target`=60 with `target_vld`, then `start` pulse → `gate_en`=1 next clock. `mod` increments every 4 clocks and reaches 60 after 240 clocks. `at_target`=1.
- **Reversal:** in RUN at 60, load `target`=-60 → `mod` decrements monotonically through 0 to -60 in 480 clocks, with no overshoot.
- **Stop:** `stop` at `mod`=-60 → STOP, 0 reached in 240 clocks, then IDLE with `gate_en`=0 one clock later. `start` mid-STOP at -30 → RUN resumes toward `tgt_q`.
- **Fault:** `fault` during ramp at `mod`=25 → next clock `mod`=0, `gate_en`=0, `state`=3. `fault_clr` while `fault`=1 has no effect. After `fault`=0 plus `fault_clr` → IDLE.
- **Clamp and priority:** `target`=-128 → `tgt_q`=-120. `target`=127 → 120. `start`, `stop` and `fault` all high together → FAULT.
